decipher_iter: RTL



---
 rtl/decipher_iter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/decipher_iter.sv
// decipher_iter: iterative AES inverse cipher (AES-128/192/256), one round per clock.
// Define DECIPHER_ZEROIZE_EN to clear state, key and data_out when the plaintext is handed off.
module decipher_iter #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     data_in,
    input  logic [Nk*32-1:0] key_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     data_out
);
    typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} state_t;
    state_t r_fsm;
    logic [127:0] r_st;
    logic [Nk*32-1:0] r_key;
    logic [3:0] r_rnd;
    logic [128*(Nr+1)-1:0] w_sched;
    logic [127:0] w_rk [Nr+1];
    logic [127:0] w_sub, w_ark, w_imc;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box needs
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq, r;
        sq = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] v;
        v = gf_inv(b);
        return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return gf_inv(rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
        logic [31:0] co, b;
        co = 32'h0e0b0d09;
        b = '0;
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 4; j++)
                b[31-8*r -: 8] = b[31-8*r -: 8] ^ gf_mul(a[31-8*j -: 8], co[31-8*((j-r+4)%4) -: 8]);
        return b;
    endfunction

    // Round 0 key lands in the MSBs, round Nr in the LSBs
    function automatic logic [128*(Nr+1)-1:0] expand(input logic [Nk*32-1:0] k);
        logic [31:0] w [4*(Nr+1)];
        logic [31:0] t;
        logic [7:0] rc;
        logic [128*(Nr+1)-1:0] s;
        rc = 8'h01;
        s = '0;
        for (int i = 0; i < 4*(Nr+1); i++) begin
            if (i < Nk) w[i] = k[Nk*32-1-32*i -: 32];
            else begin
                t = w[i-1];
                if (i % Nk == 0) begin
                    t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = gf_mul(rc, 8'h02);
                end else if (Nk > 6 && i % Nk == 4) t = sub_word(t);
                w[i] = w[i-Nk] ^ t;
            end
            s[128*(Nr+1)-1-32*i -: 32] = w[i];
        end
        return s;
    endfunction

    assign w_sched = expand(r_key);
    for (genvar i = 0; i <= Nr; i++) begin : g_rk
        assign w_rk[i] = w_sched[128*(Nr+1-i)-1 -: 128];
    end

    always_comb begin
        w_sub = '0;
        w_imc = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                w_sub[127-8*(4*c+r) -: 8] = inv_sbox(r_st[127-8*(4*((c-r+4)%4)+r) -: 8]);
        w_ark = w_sub ^ w_rk[r_fsm == FINAL ? 4'd0 : r_rnd];
        for (int c = 0; c < 4; c++)
            w_imc[127-32*c -: 32] = inv_mix_col(w_ark[127-32*c -: 32]);
    end

    assign in_ready = (r_fsm == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm     <= IDLE;
            r_st      <= '0;
            r_key     <= '0;
            r_rnd     <= '0;
            out_valid <= 1'b0;
            data_out  <= '0;
        end else begin
            case (r_fsm)
                IDLE: if (in_valid) begin
                    r_st  <= data_in;
                    r_key <= key_in;
                    r_fsm <= INIT;
                end
                INIT: begin
                    r_st  <= r_st ^ w_rk[Nr];
                    r_rnd <= 4'(Nr - 1);
                    r_fsm <= ROUND;
                end
                ROUND: begin
                    r_st  <= w_imc;
                    r_rnd <= r_rnd - 4'd1;
                    if (r_rnd == 4'd1) r_fsm <= FINAL;
                end
                FINAL: begin
                    data_out  <= w_ark;
                    out_valid <= 1'b1;
                    r_fsm     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    r_fsm     <= IDLE;
`ifdef DECIPHER_ZEROIZE_EN
                    r_st      <= '0;
                    r_key     <= '0;
                    data_out  <= '0;
`endif
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end
endmodule
